dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_resp_if.sv | 29 ++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_resp.sv | 109 ++++++++++
 tb/tb_dmem_resp.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory response block: access size, FSM state,
// and the alignment rule used to flag misaligned accesses.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_RESP   = 2'd2
  } dmem_state_e;

  // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
  function automatic logic is_misaligned(mem_size_e sz, logic [2:0] off);
    case (sz)
      MEM_B:   return 1'b0;
      MEM_H:   return off[0];
      MEM_W:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response handshake bundle between a load/store unit and dmem_resp.
interface dmem_resp_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_misaligned;
  logic        o_rsp_oob;

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned, o_rsp_oob
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned, o_rsp_oob
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes/shift and load extract/extend.
// Purely combinational; the memory word is always 64-bit little-endian.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [2:0]  i_offset,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata_sh,
  output logic [63:0] o_rdata_ext
);

  logic [7:0]  w_be_base;
  logic [63:0] w_rsh;

  // Store side: size mask and data both slide up to the addressed byte.
  always_comb begin
    case (i_size)
      MEM_B:   w_be_base = 8'h01;
      MEM_H:   w_be_base = 8'h03;
      MEM_W:   w_be_base = 8'h0F;
      default: w_be_base = 8'hFF;
    endcase
    o_be       = w_be_base << i_offset;
    o_wdata_sh = i_wdata << {i_offset, 3'b000};
  end

  // Load side: bring addressed byte to bit 0, then zero- or sign-extend.
  always_comb begin
    w_rsh = i_rword >> {i_offset, 3'b000};
    case (i_size)
      MEM_B:   o_rdata_ext = i_unsigned ? {56'd0, w_rsh[7:0]}
                                        : {{56{w_rsh[7]}}, w_rsh[7:0]};
      MEM_H:   o_rdata_ext = i_unsigned ? {48'd0, w_rsh[15:0]}
                                        : {{48{w_rsh[15]}}, w_rsh[15:0]};
      MEM_W:   o_rdata_ext = i_unsigned ? {32'd0, w_rsh[31:0]}
                                        : {{32{w_rsh[31]}}, w_rsh[31:0]};
      default: o_rdata_ext = w_rsh;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data memory: IDLE accepts, ACCESS touches the array,
// RESP holds the response until consumed. Errors block writes and zero data.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int    DEPTH      = 512,
  parameter int    ADDR_WIDTH = $clog2(DEPTH),
  parameter string INIT_FILE  = "datamem.dat"
) (
  input  logic         clk,
  input  logic         rst_,
  dmem_resp_if.slave   bus
);

  dmem_state_e r_state, w_state_nxt;

  logic        r_we;
  mem_size_e   r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rword;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [2:0]            w_off;
  logic                  w_mis;
  logic                  w_oob;
  logic                  w_err;
  logic [7:0]            w_be;
  logic [63:0]           w_wsh;
  logic [63:0]           w_ext;

  assign w_idx = r_addr[3 +: ADDR_WIDTH];
  assign w_off = r_addr[2:0];
  assign w_mis = is_misaligned(r_size, w_off);
  assign w_oob = (r_addr[63:3] >= 61'(DEPTH));
  assign w_err = w_mis | w_oob;

  dmem_lane_align u_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_offset    (w_off),
    .i_wdata     (r_wdata),
    .i_rword     (r_rword),
    .o_be        (w_be),
    .o_wdata_sh  (w_wsh),
    .o_rdata_ext (w_ext)
  );

  // Ready is gated by reset so nothing looks acceptable while held in reset.
  assign bus.o_req_ready = (r_state == DMEM_IDLE) & rst_;
  assign w_accept        = bus.o_req_ready & bus.i_req_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= DMEM_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: ACCESS is always exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DMEM_IDLE:   if (w_accept)        w_state_nxt = DMEM_ACCESS;
      DMEM_ACCESS:                      w_state_nxt = DMEM_RESP;
      DMEM_RESP:   if (bus.i_rsp_ready) w_state_nxt = DMEM_IDLE;
      default:                          w_state_nxt = DMEM_IDLE;
    endcase
  end

  // Request capture on accept; fields are frozen for the rest of the transaction.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_we       <= 1'b0;
      r_size     <= MEM_B;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= bus.i_req_we;
      r_size     <= mem_size_e'(bus.i_req_size);
      r_unsigned <= bus.i_req_unsigned;
      r_addr     <= bus.i_req_addr;
      r_wdata    <= bus.i_req_wdata;
    end
  end

  // Array access on the ACCESS edge; keyed on the async-reset state so a
  // reset landing in ACCESS cancels the write. Contents are never reset.
  always_ff @(posedge clk) begin
    if (r_state == DMEM_ACCESS && !w_err) begin
      if (r_we) begin
        for (int b = 0; b < 8; b++)
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
      r_rword <= r_mem[w_idx];
    end
  end

  // Response is derived from frozen captured state, so it is stable in RESP.
  assign bus.o_rsp_valid      = (r_state == DMEM_RESP);
  assign bus.o_rsp_misaligned = bus.o_rsp_valid & w_mis;
  assign bus.o_rsp_oob        = bus.o_rsp_valid & ~w_mis & w_oob;
  assign bus.o_rsp_rdata      = (bus.o_rsp_valid && !r_we && !w_err) ? w_ext : 64'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: vector table plus backpressure and reset-in-ACCESS sequences.
module tb_dmem_resp;
  import dmem_pkg::*;

  logic clk;
  logic rst_;
  dmem_resp_if bus();

  dmem_resp #(.DEPTH(512), .INIT_FILE("")) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mis;
    logic        oob;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [63:0] a, input logic [63:0] wd,
                     input logic [63:0] rd, input logic mis, input logic oob);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.mis = mis; v.oob = oob;
    vecs.push_back(v);
  endtask

  // Present a request at a negedge and return once the accept edge has passed.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    int n;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_size = sz;
    bus.i_req_unsigned = uns; bus.i_req_addr = a; bus.i_req_wdata = wd;
    n = 0;
    while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin errors++; checks++; $display("FAIL req_ready_timeout actual=0 expected=1"); end
    @(posedge clk);
    #1;
    // Scramble request fields after accept; they must be ignored.
    bus.i_req_valid = 1'b0; bus.i_req_we = ~we; bus.i_req_size = ~sz;
    bus.i_req_unsigned = ~uns; bus.i_req_addr = ~a; bus.i_req_wdata = ~wd;
  endtask

  // Count negedges after accept until the response shows up.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.o_rsp_valid && lat < 20);
    if (!bus.o_rsp_valid) begin errors++; checks++; $display("FAIL rsp_valid_timeout actual=0 expected=1"); end
  endtask

  task automatic consume();
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [63:0] a, input logic [63:0] wd,
                     output logic [63:0] rd, output logic mis, output logic oob, output int lat);
    issue(we, sz, uns, a, wd);
    wait_rsp(lat);
    rd = bus.o_rsp_rdata; mis = bus.o_rsp_misaligned; oob = bus.o_rsp_oob;
    consume();
  endtask

  initial begin
    logic [63:0] rd;
    logic mis, oob;
    int lat;
    logic seen;

    // Vector table: we, size(B0 H1 W2 D3), unsigned, addr, wdata, rdata, mis, oob
    add(1, 3, 0, 64'h10,   64'h1122334455667788, 64'h0,                0, 0);
    add(0, 3, 0, 64'h10,   64'h0,                64'h1122334455667788, 0, 0);
    add(1, 0, 0, 64'h13,   64'h80,               64'h0,                0, 0);
    add(0, 0, 0, 64'h13,   64'h0,                64'hFFFFFFFFFFFFFF80, 0, 0);
    add(0, 0, 1, 64'h13,   64'h0,                64'h80,               0, 0);
    add(0, 3, 0, 64'h10,   64'h0,                64'h1122334480667788, 0, 0);
    add(0, 2, 0, 64'h12,   64'h0,                64'h0,                1, 0);
    add(1, 1, 0, 64'h11,   64'hBEEF,             64'h0,                1, 0);
    add(0, 3, 0, 64'h10,   64'h0,                64'h1122334480667788, 0, 0);
    add(1, 0, 0, 64'h11,   64'hFFFFFFFFFFFFFF42, 64'h0,                0, 0);
    add(0, 3, 1, 64'h10,   64'h0,                64'h1122334480664288, 0, 0);
    add(0, 3, 0, 64'h1000, 64'h0,                64'h0,                0, 1);
    add(1, 3, 0, 64'h1004, 64'h5555,             64'h0,                1, 0);
    add(0, 1, 0, 64'h14,   64'h0,                64'h3344,             0, 0);
    add(0, 2, 0, 64'h14,   64'h0,                64'h11223344,         0, 0);
    add(1, 1, 0, 64'h1A,   64'h8001,             64'h0,                0, 0);
    add(0, 1, 0, 64'h1A,   64'h0,                64'hFFFFFFFFFFFF8001, 0, 0);
    add(0, 1, 1, 64'h1A,   64'h0,                64'h8001,             0, 0);
    add(1, 2, 0, 64'h1C,   64'hDEADBEEF,         64'h0,                0, 0);
    add(0, 2, 0, 64'h1C,   64'h0,                64'hFFFFFFFFDEADBEEF, 0, 0);
    add(0, 2, 1, 64'h1C,   64'h0,                64'hDEADBEEF,         0, 0);
    add(0, 0, 0, 64'h1D,   64'h0,                64'hFFFFFFFFFFFFFFBE, 0, 0);
    add(1, 3, 0, 64'h00,   64'hA5A5A5A5A5A5A5A5, 64'h0,                0, 0);
    add(1, 3, 0, 64'h1000, 64'h0123012301230123, 64'h0,                0, 1);
    add(0, 3, 1, 64'h00,   64'h0,                64'hA5A5A5A5A5A5A5A5, 0, 0);

    bus.i_req_valid = 0; bus.i_req_we = 0; bus.i_req_size = 0; bus.i_req_unsigned = 0;
    bus.i_req_addr = 0; bus.i_req_wdata = 0; bus.i_rsp_ready = 0;

    // Reset state
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_rdata", bus.o_rsp_rdata, 64'd0);
    chk("rst_flags", 64'({bus.o_rsp_misaligned, bus.o_rsp_oob}), 64'd0);
    rst_ = 1'b1;
    #1 chk("post_rst_req_ready", 64'(bus.o_req_ready), 64'd1);

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, mis, oob, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_misaligned", i), 64'(mis), 64'(vecs[i].mis));
      chk($sformatf("v%0d_oob", i), 64'(oob), 64'(vecs[i].oob));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
    end

    // Backpressure: response held for 5 cycles must not move.
    issue(0, 3, 0, 64'h10, 64'h0);
    wait_rsp(lat);
    chk("bp_latency", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 64'(bus.o_rsp_valid), 64'd1);
      chk($sformatf("bp%0d_rdata", k), bus.o_rsp_rdata, 64'h1122334480664288);
      chk($sformatf("bp%0d_req_ready", k), 64'(bus.o_req_ready), 64'd0);
      @(negedge clk);
    end
    consume();
    @(negedge clk);
    chk("bp_ready_after_hs", 64'(bus.o_req_ready), 64'd1);
    chk("bp_valid_after_hs", 64'(bus.o_rsp_valid), 64'd0);

    // Reset landing in ACCESS of a store cancels it.
    txn(1, 3, 0, 64'h20, 64'h0123456789ABCDEF, rd, mis, oob, lat);
    issue(1, 3, 0, 64'h20, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("rstacc_req_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rstacc_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    #1 chk("rstacc_ready_release", 64'(bus.o_req_ready), 64'd1);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= bus.o_rsp_valid; end
    chk("rstacc_no_rsp", 64'(seen), 64'd0);
    txn(0, 3, 0, 64'h20, 64'h0, rd, mis, oob, lat);
    chk("rstacc_readback", rd, 64'h0123456789ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
